core_pixel_pack: RTL and testbench

- Reader/packer on the output-buffer side of the rotation core.
- Once a rotated 8x8 tile (64 RGB pixels, 192 bytes) is complete in the output buffer, it issues 4-lane byte reads to the buffer and packs each group of four bytes into one 32-bit word.
- Words go to the DMA/AHB master over a valid/ready handshake with backpressure.
- Completes the return path that mirrors the AHB-to-input-buffer write path.

---
 rtl/core_pixel_pack.sv | 147 ++++++++++++++
 tb/tb_core_pixel_pack.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pixel_pack.sv
// core_pixel_pack: once a rotated tile is complete in the output buffer, reads it four bytes
// at a time and streams packed 32-bit words to the DMA master over valid/ready.
module core_pixel_pack #(
  parameter int TILE_BYTES = 192,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET_N,
  input  logic              I_START,
  input  logic              I_CLEAR,
  input  logic              I_TILE_READY,
  output logic              O_RD_EN,
  output logic [ADDR_W-1:0] O_RD_ADDR0,
  output logic [ADDR_W-1:0] O_RD_ADDR1,
  output logic [ADDR_W-1:0] O_RD_ADDR2,
  output logic [ADDR_W-1:0] O_RD_ADDR3,
  input  logic [7:0]        I_RD_DATA0,
  input  logic [7:0]        I_RD_DATA1,
  input  logic [7:0]        I_RD_DATA2,
  input  logic [7:0]        I_RD_DATA3,
  output logic [31:0]       O_WDATA,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [5:0]        O_WORD_CNT,
  output logic              O_BUSY,
  output logic              O_DONE
);

  localparam int WORDS = TILE_BYTES / 4;
  localparam int ISS_W = $clog2(WORDS + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [ISS_W-1:0] issued;
  logic             inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic             rd_en, push, pop, fifo_empty, last_issue, enter_read;

  // A read is only issued when its returning word is guaranteed a FIFO slot.
  assign fifo_empty = (fifo_count == '0);
  assign push       = inflight;
  assign pop        = !fifo_empty && I_READY;
  assign rd_en      = (state == S_READ) && (issued < ISS_W'(WORDS)) &&
                      ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign last_issue = rd_en && (issued == ISS_W'(WORDS - 1));
  assign enter_read = (state == S_WAIT) && I_TILE_READY && !I_CLEAR;

  assign O_RD_EN = rd_en;
  assign O_VALID = !fifo_empty;
  assign O_WDATA = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
  assign O_BUSY  = (state != S_IDLE);
  assign O_DONE  = (state == S_DONE);

  // NOTE: clocked blocks use <= so every register samples pre-edge values regardless of order.
  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    // NOTE: next state is defaulted first so no path through the case can infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (I_START)      state_nxt = S_WAIT;
      S_WAIT:  if (I_TILE_READY) state_nxt = S_READ;
      S_READ:  if (last_issue)   state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty && !inflight) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_WAIT;
      default: state_nxt = S_IDLE;
    endcase
    if (I_CLEAR) state_nxt = S_IDLE;
  end

  // Issue counter, lane addresses, in-flight flag and accepted-word counter.
  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      issued     <= '0;
      inflight   <= 1'b0;
      O_RD_ADDR0 <= '0;
      O_RD_ADDR1 <= '0;
      O_RD_ADDR2 <= '0;
      O_RD_ADDR3 <= '0;
      O_WORD_CNT <= '0;
    end else if (I_CLEAR) begin
      issued     <= '0;
      inflight   <= 1'b0;
      O_RD_ADDR0 <= '0;
      O_RD_ADDR1 <= '0;
      O_RD_ADDR2 <= '0;
      O_RD_ADDR3 <= '0;
      O_WORD_CNT <= '0;
    end else begin
      inflight <= rd_en;
      if (enter_read) begin
        issued     <= '0;
        O_RD_ADDR0 <= ADDR_W'(0);
        O_RD_ADDR1 <= ADDR_W'(1);
        O_RD_ADDR2 <= ADDR_W'(2);
        O_RD_ADDR3 <= ADDR_W'(3);
        O_WORD_CNT <= '0;
      end else begin
        if (rd_en) begin
          issued     <= issued + 1'b1;
          O_RD_ADDR0 <= O_RD_ADDR0 + ADDR_W'(4);
          O_RD_ADDR1 <= O_RD_ADDR1 + ADDR_W'(4);
          O_RD_ADDR2 <= O_RD_ADDR2 + ADDR_W'(4);
          O_RD_ADDR3 <= O_RD_ADDR3 + ADDR_W'(4);
        end
        if (pop && (O_WORD_CNT != 6'(WORDS))) O_WORD_CNT <= O_WORD_CNT + 1'b1;
      end
    end
  end

  // FIFO bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (I_CLEAR) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is not reset; fifo_count alone says which entries are live, and
  // O_WDATA is forced to zero while the FIFO is empty.
  always_ff @(posedge I_HCLK) begin
    if (push && !I_CLEAR) fifo_mem[wr_ptr] <= {I_RD_DATA3, I_RD_DATA2, I_RD_DATA1, I_RD_DATA0};
  end

endmodule

// File: tb/tb_core_pixel_pack.sv
// Bench for core_pixel_pack: control-vector table, an output-buffer model returning
// byte[a] = a, and a scoreboard of expected packed words.
module tb_core_pixel_pack;

  localparam int ADDR_W = 8;
  localparam int WORDS  = 48;
  localparam int DEPTH  = 2;

  logic              I_HCLK = 1'b0;
  logic              I_HRESET_N = 1'b1;
  logic              I_START = 1'b0, I_CLEAR = 1'b0, I_TILE_READY = 1'b0, I_READY = 1'b0;
  logic              O_RD_EN, O_VALID, O_BUSY, O_DONE;
  logic [ADDR_W-1:0] O_RD_ADDR0, O_RD_ADDR1, O_RD_ADDR2, O_RD_ADDR3;
  logic [7:0]        I_RD_DATA0 = 8'h0, I_RD_DATA1 = 8'h0, I_RD_DATA2 = 8'h0, I_RD_DATA3 = 8'h0;
  logic [31:0]       O_WDATA;
  logic [5:0]        O_WORD_CNT;

  core_pixel_pack #(.TILE_BYTES(192), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .I_HCLK(I_HCLK), .I_HRESET_N(I_HRESET_N), .I_START(I_START), .I_CLEAR(I_CLEAR),
    .I_TILE_READY(I_TILE_READY), .O_RD_EN(O_RD_EN),
    .O_RD_ADDR0(O_RD_ADDR0), .O_RD_ADDR1(O_RD_ADDR1), .O_RD_ADDR2(O_RD_ADDR2), .O_RD_ADDR3(O_RD_ADDR3),
    .I_RD_DATA0(I_RD_DATA0), .I_RD_DATA1(I_RD_DATA1), .I_RD_DATA2(I_RD_DATA2), .I_RD_DATA3(I_RD_DATA3),
    .O_WDATA(O_WDATA), .O_VALID(O_VALID), .I_READY(I_READY), .O_WORD_CNT(O_WORD_CNT),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE)
  );

  always #5 I_HCLK = ~I_HCLK;

  // Output buffer: byte[a] = a, valid only in the cycle after the strobe.
  always @(posedge I_HCLK) begin
    if (O_RD_EN) begin
      I_RD_DATA0 <= O_RD_ADDR0;
      I_RD_DATA1 <= O_RD_ADDR1;
      I_RD_DATA2 <= O_RD_ADDR2;
      I_RD_DATA3 <= O_RD_ADDR3;
    end else begin
      I_RD_DATA0 <= 8'hEE;
      I_RD_DATA1 <= 8'hEE;
      I_RD_DATA2 <= 8'hEE;
      I_RD_DATA3 <= 8'hEE;
    end
  end

  typedef struct packed {
    logic       start, clear, tile;
    logic       busy, rd_en, valid, done;
    logic [5:0] cnt;
  } vec_t;

  vec_t        tbl [18];
  int          n_vec = 0, n_err = 0;
  int          words_seen = 0, done_cnt = 0, cyc = 0, first_rd = -1, first_v = -1;
  int          m_count = 0, exp_iss = 0;
  bit          m_inflight = 1'b0;
  logic [31:0] first_word = 32'h0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic flush_model();
    exp_q.delete();
    m_count    = 0;
    m_inflight = 1'b0;
    exp_iss    = 0;
  endtask

  task automatic push_tile();
    for (int i = 0; i < WORDS; i++) begin
      logic [7:0] b;
      b = 8'(4 * i);
      exp_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
  endtask

  // Per-cycle scoreboard/monitor, sampled on the falling edge.
  task automatic monitor();
    logic [31:0] exp_w;
    logic [7:0]  b;
    bit          pop;
    cyc++;
    if (!I_HRESET_N) begin
      flush_model();
      return;
    end
    pop = O_VALID && I_READY;
    check("valid_vs_fifo_model", 32'(O_VALID), 32'(m_count != 0));
    if (pop) begin
      if (words_seen == 0) first_word = O_WDATA;
      words_seen++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_word: actual 0x%08h, expected no word", O_WDATA);
      end else begin
        exp_w = exp_q.pop_front();
        check("wdata", O_WDATA, exp_w);
      end
    end
    if (m_count + int'(m_inflight) >= DEPTH) check("rd_en_gate", 32'(O_RD_EN), 32'h0);
    if (O_RD_EN) begin
      if (first_rd < 0) first_rd = cyc;
      b = 8'(exp_iss * 4);
      check("rd_addr", {O_RD_ADDR3, O_RD_ADDR2, O_RD_ADDR1, O_RD_ADDR0},
            {b + 8'd3, b + 8'd2, b + 8'd1, b});
      exp_iss = (exp_iss + 1) % WORDS;
    end
    if (O_VALID && first_v < 0) first_v = cyc;
    if (O_DONE) done_cnt++;
    if (I_CLEAR) flush_model();
    else begin
      m_count    = m_count + int'(m_inflight) - int'(pop);
      m_inflight = O_RD_EN;
    end
  endtask

  task automatic step();
    @(negedge I_HCLK);
    monitor();
    @(posedge I_HCLK);
    #1;
  endtask

  task automatic start_tile();
    I_START = 1'b1;
    step();
    I_START      = 1'b0;
    I_TILE_READY = 1'b1;
    step();
    I_TILE_READY = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt < target; i++) step();
    if (done_cnt < target) fail_timeout(name);
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    for (int i = 0; i < budget && words_seen < target; i++) step();
    if (words_seen < target) fail_timeout(name);
  endtask

  task automatic do_clear();
    I_READY = 1'b0;
    I_CLEAR = 1'b1;
    step();
    I_CLEAR = 1'b0;
  endtask

  task automatic reset_counts();
    words_seen = 0;
    done_cnt   = 0;
    first_rd   = -1;
    first_v    = -1;
  endtask

  function automatic vec_t mk(input logic s, c, t, bz, rd, v, d);
    vec_t r;
    r = '{start: s, clear: c, tile: t, busy: bz, rd_en: rd, valid: v, done: d, cnt: 6'd0};
    return r;
  endfunction

  initial begin
    // start clear tile | busy rd_en valid done  (expected after the edge)
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 0, 0, 0);  // clear beats start
    tbl[2]  = mk(1, 0, 0, 1, 0, 0, 0);  // into WAIT
    for (int i = 3; i < 13; i++) tbl[i] = mk(0, 0, 0, 1, 0, 0, 0);  // tile not ready
    tbl[13] = mk(0, 0, 1, 1, 1, 0, 0);  // READ, first strobe
    tbl[14] = mk(0, 0, 0, 1, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, 1, 0);  // valid 2 cycles after first strobe
    tbl[16] = mk(0, 0, 0, 1, 0, 1, 0);  // FIFO full, no strobe
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 0);  // clear

    #3 I_HRESET_N = 1'b0;
    #1;
    check("reset_outputs", {O_RD_EN, O_VALID, O_BUSY, O_DONE, O_WORD_CNT}, 32'h0);
    check("reset_addr", {O_RD_ADDR3, O_RD_ADDR2, O_RD_ADDR1, O_RD_ADDR0}, 32'h0);
    check("reset_wdata", O_WDATA, 32'h0);
    repeat (3) @(posedge I_HCLK);
    #1 I_HRESET_N = 1'b1;

    for (int i = 0; i < 18; i++) begin
      I_START      = tbl[i].start;
      I_CLEAR      = tbl[i].clear;
      I_TILE_READY = tbl[i].tile;
      step();
      check($sformatf("tbl%0d_busy", i),  32'(O_BUSY),     32'(tbl[i].busy));
      check($sformatf("tbl%0d_rd_en", i), 32'(O_RD_EN),    32'(tbl[i].rd_en));
      check($sformatf("tbl%0d_valid", i), 32'(O_VALID),    32'(tbl[i].valid));
      check($sformatf("tbl%0d_done", i),  32'(O_DONE),     32'(tbl[i].done));
      check($sformatf("tbl%0d_cnt", i),   32'(O_WORD_CNT), 32'(tbl[i].cnt));
    end
    I_START = 1'b0;
    I_CLEAR = 1'b0;
    I_TILE_READY = 1'b0;

    // Full rate, single tile.
    reset_counts();
    I_READY = 1'b1;
    push_tile();
    start_tile();
    wait_done(1, 400, "full_rate_done");
    check("full_first_valid_latency", 32'(first_v - first_rd), 32'd2);
    check("full_words", 32'(words_seen), 32'd48);
    check("full_word_cnt", 32'(O_WORD_CNT), 32'd48);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    check("full_single_done", 32'(done_cnt), 32'd1);
    check("full_idle_wait_busy", 32'(O_BUSY), 32'd1);
    check("full_cnt_held", 32'(O_WORD_CNT), 32'd48);
    do_clear();

    // Backpressure at word 10.
    reset_counts();
    I_READY = 1'b1;
    push_tile();
    start_tile();
    wait_words(10, 200, "bp_reach_word10");
    I_READY = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k >= 3) begin
        check("bp_valid_held", 32'(O_VALID), 32'd1);
        check("bp_wdata_held", O_WDATA, 32'h2B2A2928);
        check("bp_no_strobe", 32'(O_RD_EN), 32'd0);
      end
    end
    I_READY = 1'b1;
    wait_done(1, 400, "bp_done");
    check("bp_words", 32'(words_seen), 32'd48);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    do_clear();

    // Random ready over three back-to-back tiles.
    reset_counts();
    push_tile();
    push_tile();
    push_tile();
    I_START = 1'b1;
    step();
    I_START = 1'b0;
    I_TILE_READY = 1'b1;
    for (int i = 0; i < 3000 && done_cnt < 3; i++) begin
      I_READY = 1'($urandom_range(0, 1));
      step();
      if (done_cnt < 3) check("rand_busy", 32'(O_BUSY), 32'd1);
    end
    I_TILE_READY = 1'b0;
    I_READY = 1'b0;
    if (done_cnt < 3) fail_timeout("rand_three_tiles");
    check("rand_words", 32'(words_seen), 32'd144);
    check("rand_done_pulses", 32'(done_cnt), 32'd3);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    step();
    check("rand_parked_no_strobe", 32'(O_RD_EN), 32'd0);
    do_clear();

    // Asynchronous reset at word 20.
    reset_counts();
    I_READY = 1'b1;
    push_tile();
    start_tile();
    wait_words(20, 300, "rst_reach_word20");
    I_HRESET_N = 1'b0;
    #1;
    check("rst_mid_ctl", {O_RD_EN, O_VALID, O_BUSY, O_DONE, O_WORD_CNT}, 32'h0);
    check("rst_mid_addr", {O_RD_ADDR3, O_RD_ADDR2, O_RD_ADDR1, O_RD_ADDR0}, 32'h0);
    check("rst_mid_wdata", O_WDATA, 32'h0);
    step();
    step();
    I_HRESET_N = 1'b1;
    step();
    reset_counts();
    push_tile();
    start_tile();
    wait_done(1, 400, "rst_restart_done");
    check("rst_restart_first_word", first_word, 32'h03020100);
    check("rst_restart_words", 32'(words_seen), 32'd48);
    do_clear();

    // Clear at word 30 with the FIFO full.
    reset_counts();
    I_READY = 1'b1;
    push_tile();
    start_tile();
    wait_words(30, 300, "clr_reach_word30");
    I_READY = 1'b0;
    repeat (3) step();
    check("clr_full_valid", 32'(O_VALID), 32'd1);
    check("clr_full_no_strobe", 32'(O_RD_EN), 32'd0);
    check("clr_full_head", O_WDATA, 32'h7B7A7978);
    do_clear();
    check("clr_busy", 32'(O_BUSY), 32'd0);
    check("clr_valid", 32'(O_VALID), 32'd0);
    check("clr_word_cnt", 32'(O_WORD_CNT), 32'd0);
    repeat (5) step();
    check("clr_no_done", 32'(done_cnt), 32'd0);
    check("clr_stays_idle", 32'(O_BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
